// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if.sv - core-side request/response bundle of the load/store control stage.
// master = core side (issues requests, consumes responses), slave = lsu_ctrl.
interface lsu_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl.sv - load/store control stage in front of the word-organised data memory.
// Takes one request at a time, drives the memory address/lane/strobe lines for a
// single ACCESS cycle and returns a registered, sign/zero-extended response.
// Build macro: LSU_MISALIGN_TRAP_EN - when defined, misaligned half/word accesses
// are reported as errors; when undefined, the misaligning low address bits are
// forced to zero and the access completes normally.
module lsu_ctrl #(
    parameter int ADDR_W        = 32,
    parameter int MEM_WORDS_LG2 = 7
) (
    input  logic                     clk,
    input  logic                     rstn,
    lsu_ctrl_if.slave                bus,
    output logic [MEM_WORDS_LG2-1:0] DMAdd,
    output logic [1:0]               LastTwo,
    output logic                     SpecialIn,
    output logic                     BorH,
    output logic [31:0]              DataIn,
    output logic                     DMW,
    output logic                     DMR,
    input  logic [31:0]              DataOut
);
    // First address bit beyond the memory; any set bit from here up is out of range.
    localparam int HI_LSB = MEM_WORDS_LG2 + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t                   state_r;
    state_t                   next_state_s;
    logic                     accept_s;
    logic                     size_err_s;
    logic                     range_err_s;
    logic                     align_err_s;
    logic                     err_s;
    logic [1:0]               low_s;

    logic                     req_ready_r;
    logic                     rsp_valid_r;
    logic                     rsp_err_r;
    logic [31:0]              rsp_rdata_r;
    logic                     we_r;
    logic                     uns_r;
    logic [1:0]               size_r;
    logic [MEM_WORDS_LG2-1:0] dm_add_r;
    logic [1:0]               last_two_r;
    logic                     special_r;
    logic                     borh_r;
    logic [31:0]              data_in_r;
    logic                     dmw_r;
    logic                     dmr_r;

    // Selects the addressed byte/half lane of a memory word and extends it to 32 bits.
    function automatic logic [31:0] extract_load(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        if (lane[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (size)
            2'b00:   r = {{24{~uns & b[7]}}, b};
            2'b01:   r = {{16{~uns & h[15]}}, h};
            2'b10:   r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Classifies the presented request and computes its effective low address bits.
    always_comb begin
        size_err_s  = (bus.req_size == 2'b11);
        range_err_s = |bus.req_addr[ADDR_W-1:HI_LSB];
`ifdef LSU_MISALIGN_TRAP_EN
        case (bus.req_size)
            2'b01:   align_err_s = bus.req_addr[0];
            2'b10:   align_err_s = |bus.req_addr[1:0];
            default: align_err_s = 1'b0;
        endcase
        low_s = bus.req_addr[1:0];
`else
        align_err_s = 1'b0;
        case (bus.req_size)
            2'b01:   low_s = {bus.req_addr[1], 1'b0};
            2'b10:   low_s = 2'b00;
            default: low_s = bus.req_addr[1:0];
        endcase
`endif
        err_s = size_err_s | range_err_s | align_err_s;
    end

    // Next-state decode: legal requests go through ACCESS, erroring ones skip to RESP.
    always_comb begin
        accept_s     = (state_r == IDLE) && bus.req_valid && req_ready_r;
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = err_s ? RESP : ACCESS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCESS: next_state_s = RESP;
            RESP: begin
                if (rsp_valid_r && bus.rsp_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // FSM state, request latch, memory strobes and registered response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            we_r        <= 1'b0;
            uns_r       <= 1'b0;
            size_r      <= 2'b00;
            dm_add_r    <= '0;
            last_two_r  <= 2'b00;
            special_r   <= 1'b0;
            borh_r      <= 1'b0;
            data_in_r   <= 32'h0000_0000;
            dmw_r       <= 1'b0;
            dmr_r       <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            req_ready_r <= (next_state_s == IDLE);
            rsp_valid_r <= (next_state_s == RESP);
            dmw_r       <= 1'b0;
            dmr_r       <= 1'b0;
            if (accept_s) begin
                we_r        <= bus.req_we;
                uns_r       <= bus.req_unsigned;
                size_r      <= bus.req_size;
                dm_add_r    <= bus.req_addr[HI_LSB-1:2];
                last_two_r  <= low_s;
                special_r   <= (bus.req_size == 2'b00) || (bus.req_size == 2'b01);
                borh_r      <= (bus.req_size == 2'b01);
                data_in_r   <= bus.req_wdata;
                rsp_err_r   <= err_s;
                rsp_rdata_r <= 32'h0000_0000;
                dmw_r       <= ~err_s & bus.req_we;
                dmr_r       <= ~err_s & ~bus.req_we;
            end else if (state_r == ACCESS) begin
                if (we_r) begin
                    rsp_rdata_r <= 32'h0000_0000;
                end else begin
                    rsp_rdata_r <= extract_load(DataOut, last_two_r, size_r, uns_r);
                end
            end
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
    assign DMAdd         = dm_add_r;
    assign LastTwo       = last_two_r;
    assign SpecialIn     = special_r;
    assign BorH          = borh_r;
    assign DataIn        = data_in_r;
    assign DMW           = dmw_r;
    assign DMR           = dmr_r;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl with a byte-addressed reference memory.
module tb_lsu_ctrl;
    localparam int ADDR_W = 32;
    localparam int LG2    = 7;

    logic           clk  = 1'b0;
    logic           rstn = 1'b0;
    logic [LG2-1:0] DMAdd;
    logic [1:0]     LastTwo;
    logic           SpecialIn;
    logic           BorH;
    logic [31:0]    DataIn;
    logic           DMW;
    logic           DMR;
    logic [31:0]    DataOut;

    lsu_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    lsu_ctrl #(.ADDR_W(ADDR_W), .MEM_WORDS_LG2(LG2)) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .DMAdd(DMAdd), .LastTwo(LastTwo), .SpecialIn(SpecialIn), .BorH(BorH),
        .DataIn(DataIn), .DMW(DMW), .DMR(DMR), .DataOut(DataOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          ndmw;
        int          ndmr;
        logic [6:0]  widx;
        logic [1:0]  lt;
        logic        sp;
        logic        bh;
        logic [31:0] wd;
        int          acc_cyc;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic        hold    = 1'b0;
    logic        init_phase = 1'b1;
    logic [7:0]  ref_mem [0:511];
    logic [31:0] env_mem [0:127];

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory stand-in: combinational read, lane-selected write on the clock edge.
    assign DataOut = env_mem[DMAdd];
    always @(posedge clk) begin
        if (init_phase) begin
            for (int i = 0; i < 128; i++) env_mem[i] <= init_word(i);
        end else if (DMW) begin
            if (!SpecialIn)  env_mem[DMAdd] <= DataIn;
            else if (BorH)   env_mem[DMAdd][{LastTwo[1], 4'b0000} +: 16] <= DataIn[15:0];
            else             env_mem[DMAdd][{LastTwo, 3'b000} +: 8] <= DataIn[7:0];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: byte-array memory, natural alignment by integer arithmetic.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic err, output logic [31:0] rd, output logic [31:0] ea);
        int nb;
        logic [31:0] v;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err = (sz == 2'd3) || (addr >= 32'd512);
`ifdef LSU_MISALIGN_TRAP_EN
        if (!err && (addr % nb) != 0) err = 1'b1;
`endif
        ea = addr - (addr % nb);
        rd = 32'h0;
        if (!err) begin
            if (we) begin
                for (int b = 0; b < nb; b++) ref_mem[ea + b] = wd[8*b +: 8];
            end else begin
                v = 32'h0;
                for (int b = 0; b < nb; b++) v = v | (32'(ref_mem[ea + b]) << (8 * b));
                if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8 * nb)) - 32'h1);
                rd = v;
            end
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic use_k, input logic [31:0] k);
        exp_t e;
        logic err;
        logic [31:0] rd, ea;
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
        n = 0;
        while (!bus.req_ready && n < 200) begin @(negedge clk); n++; end
        if (!bus.req_ready) begin
            n_tests++; n_fail++;
            $display("FAIL req_ready_timeout: got 0, expected 1 within 200 cycles");
            bus.req_valid = 1'b0;
        end else begin
            model(we, sz, uns, addr, wd, err, rd, ea);
            e.rd = use_k ? k : rd;
            e.err = err;
            e.lat = err ? 1 : 2;
            e.ndmw = (!err && we) ? 1 : 0;
            e.ndmr = (!err && !we) ? 1 : 0;
            e.widx = ea[8:2];
            e.lt = ea[1:0];
            e.sp = (sz < 2'd2);
            e.bh = (sz == 2'd1);
            e.wd = wd;
            e.acc_cyc = cyc;
            q.push_back(e);
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        if (q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'h0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
        chk({tag, "_rsp_err"},   32'(bus.rsp_err),   32'h0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata,      32'h0);
        chk({tag, "_DMW"},       32'(DMW),           32'h0);
        chk({tag, "_DMR"},       32'(DMR),           32'h0);
        chk({tag, "_DMAdd"},     32'(DMAdd),         32'h0);
        chk({tag, "_LastTwo"},   32'(LastTwo),       32'h0);
        chk({tag, "_SpecialIn"}, 32'(SpecialIn),     32'h0);
        chk({tag, "_BorH"},      32'(BorH),          32'h0);
        chk({tag, "_DataIn"},    DataIn,             32'h0);
    endtask

    // Response ready: random back-pressure, forced low while hold is set.
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: checks memory-side activity and pops/compares responses.
    initial begin
        int dmw_cnt, dmr_cnt;
        logic seen_v;
        logic [31:0] hold_rd;
        logic hold_err;
        dmw_cnt = 0; dmr_cnt = 0; seen_v = 1'b0; hold_rd = 32'h0; hold_err = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                dmw_cnt = 0; dmr_cnt = 0; seen_v = 1'b0;
            end else begin
                if (DMW || DMR) begin
                    if (q.size() == 0) begin
                        chk("strobe_without_request", 32'(DMW | DMR), 32'h0);
                    end else begin
                        if (DMW) dmw_cnt++;
                        if (DMR) dmr_cnt++;
                        chk("DMAdd", 32'(DMAdd), 32'(q[0].widx));
                        chk("LastTwo", 32'(LastTwo), 32'(q[0].lt));
                        chk("SpecialIn", 32'(SpecialIn), 32'(q[0].sp));
                        if (q[0].sp) chk("BorH", 32'(BorH), 32'(q[0].bh));
                        if (DMW) chk("DataIn", DataIn, q[0].wd);
                    end
                end
                if (bus.rsp_valid) begin
                    if (q.size() == 0) begin
                        chk("rsp_without_request", 32'(bus.rsp_valid), 32'h0);
                    end else begin
                        if (!seen_v) begin
                            seen_v = 1'b1;
                            chk("rsp_latency", 32'(cyc - q[0].acc_cyc), 32'(q[0].lat));
                            hold_rd = bus.rsp_rdata;
                            hold_err = bus.rsp_err;
                        end else begin
                            chk("rsp_rdata_stable", bus.rsp_rdata, hold_rd);
                            chk("rsp_err_stable", 32'(bus.rsp_err), 32'(hold_err));
                        end
                        chk("req_ready_during_rsp", 32'(bus.req_ready), 32'h0);
                        if (bus.rsp_ready) begin
                            chk("rsp_rdata", bus.rsp_rdata, q[0].rd);
                            chk("rsp_err", 32'(bus.rsp_err), 32'(q[0].err));
                            chk("dmw_cycles", 32'(dmw_cnt), 32'(q[0].ndmw));
                            chk("dmr_cycles", 32'(dmr_cnt), 32'(q[0].ndmr));
                            void'(q.pop_front());
                            dmw_cnt = 0; dmr_cnt = 0; seen_v = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Main stimulus.
    initial begin
        logic [31:0] w, a, wd;
        logic [1:0] sz;
        int n, r;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        for (int i = 0; i < 128; i++) begin
            w = init_word(i);
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
        repeat (3) @(negedge clk);
        check_reset("reset");
        init_phase = 1'b0;
        rstn = 1'b1;

        // Directed cases from the block's functional description.
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF);
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h8081_F2F3, 1'b1, 32'h0);
        issue(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 1'b1, 32'hFFFF_FFF2);
        issue(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 1'b1, 32'h0000_00F2);
        issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1'b1, 32'hFFFF_8081);
        issue(1'b1, 2'd2, 1'b0, 32'h30, 32'h0, 1'b1, 32'h0);
        issue(1'b1, 2'd0, 1'b0, 32'h33, 32'h0000_005A, 1'b1, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b1, 32'h5A00_0000);
        issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 1'b1, 32'h0);
        issue(1'b0, 2'd3, 1'b0, 32'h04, 32'h0, 1'b1, 32'h0);
        issue(1'b1, 2'd3, 1'b0, 32'h08, 32'h1234_5678, 1'b1, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 1'b1, 32'h0);
`else
        issue(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 1'b1, 32'hFFFF_F2F3);
`endif
        drain();

        // Back-pressure: response must stay put while rsp_ready is low.
        hold = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 32'h8081_F2F3);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("hold_req_ready", 32'(bus.req_ready), 32'h0);
        hold = 1'b0;
        drain();

        // Reset during a store's ACCESS cycle: the store must not land.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h40; bus.req_wdata = 32'h1234_5678;
        n = 0;
        while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("abort_DMW_in_access", 32'(DMW), 32'h1);
        #1 rstn = 1'b0;
        #1 check_reset("abort");
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b1, init_word(16));
        drain();

        // Randomized traffic against the reference model.
        for (int t = 0; t < 200; t++) begin
            r = $urandom_range(0, 15);
            sz = (r == 15) ? 2'd3 : 2'(r % 3);
            a = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(9, 31));
            wd = $urandom;
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, wd, 1'b0, 32'h0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
